// File: rtl/ips_dbc_capture_wr_ctrl_v1_0.sv
// Write-side controller for the debug core capture memory: circular pre/post
// trigger window of 2^DATA_DEPTH samples with a one-cycle staged write port.
module ips_dbc_capture_wr_ctrl_v1_0 #(
  parameter int DATA_DEPTH = 9,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  arm,
  input  logic                  abort,
  input  logic [DATA_DEPTH-1:0] pre_trig_num,
  input  logic                  sample_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  trig,
  output logic                  wren,
  output logic [DATA_DEPTH-1:0] wraddress,
  output logic [DATA_WIDTH-1:0] data,
  output logic [DATA_DEPTH-1:0] trig_addr,
  output logic [DATA_DEPTH-1:0] start_addr,
  output logic                  busy,
  output logic                  triggered,
  output logic                  done
);

  localparam logic [DATA_DEPTH-1:0] LAST = '1;
  localparam logic [DATA_DEPTH-1:0] ONE  = {{(DATA_DEPTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRE       = 3'd1,
    WAIT_TRIG = 3'd2,
    POST      = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t                r_state, w_state_n;
  logic [DATA_DEPTH-1:0] r_p, w_p_n;
  logic [DATA_DEPTH-1:0] r_wr_ptr, w_wr_ptr_n;
  logic [DATA_DEPTH-1:0] r_pre_cnt, w_pre_cnt_n;
  logic [DATA_DEPTH-1:0] r_post_rem, w_post_rem_n;
  logic [DATA_DEPTH-1:0] r_wraddress, w_wraddress_n;
  logic [DATA_DEPTH-1:0] r_trig_addr, w_trig_addr_n;
  logic [DATA_DEPTH-1:0] r_start_addr, w_start_addr_n;
  logic [DATA_WIDTH-1:0] r_data, w_data_n;
  logic                  r_wren, w_wren_n;
  logic                  r_triggered, w_triggered_n;
  logic                  r_done, w_done_n;
  logic                  w_active;
  logic                  w_take;
  logic [DATA_DEPTH-1:0] w_pre_inc;

  assign w_active  = (r_state == PRE) || (r_state == WAIT_TRIG) || (r_state == POST);
  // arm discards the sample of its own cycle; abort still lets it be written
  assign w_take    = w_active && sample_en && !arm;
  assign w_pre_inc = r_pre_cnt + ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_p          <= '0;
      r_wr_ptr     <= '0;
      r_pre_cnt    <= '0;
      r_post_rem   <= '0;
      r_wraddress  <= '0;
      r_trig_addr  <= '0;
      r_start_addr <= '0;
      r_data       <= '0;
      r_wren       <= 1'b0;
      r_triggered  <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_p          <= w_p_n;
      r_wr_ptr     <= w_wr_ptr_n;
      r_pre_cnt    <= w_pre_cnt_n;
      r_post_rem   <= w_post_rem_n;
      r_wraddress  <= w_wraddress_n;
      r_trig_addr  <= w_trig_addr_n;
      r_start_addr <= w_start_addr_n;
      r_data       <= w_data_n;
      r_wren       <= w_wren_n;
      r_triggered  <= w_triggered_n;
      r_done       <= w_done_n;
    end
  end

  always_comb begin
    w_state_n      = r_state;
    w_p_n          = r_p;
    w_wr_ptr_n     = r_wr_ptr;
    w_pre_cnt_n    = r_pre_cnt;
    w_post_rem_n   = r_post_rem;
    w_wraddress_n  = r_wraddress;
    w_trig_addr_n  = r_trig_addr;
    w_start_addr_n = r_start_addr;
    w_data_n       = r_data;
    w_wren_n       = 1'b0;
    w_triggered_n  = r_triggered;
    w_done_n       = r_done;

    if (w_take) begin
      w_wren_n      = 1'b1;
      w_wraddress_n = r_wr_ptr;
      w_data_n      = din;
      w_wr_ptr_n    = r_wr_ptr + ONE;
    end

    if (arm) begin
      w_p_n         = pre_trig_num;
      w_wr_ptr_n    = '0;
      w_pre_cnt_n   = '0;
      w_triggered_n = 1'b0;
      w_done_n      = 1'b0;
      w_state_n     = (pre_trig_num != '0) ? PRE : WAIT_TRIG;
    end else if (abort) begin
      w_state_n     = IDLE;
      w_triggered_n = 1'b0;
      w_done_n      = 1'b0;
    end else if (w_take) begin
      case (r_state)
        PRE: begin
          w_pre_cnt_n = w_pre_inc;
          if (w_pre_inc == r_p) w_state_n = WAIT_TRIG;
        end
        WAIT_TRIG: begin
          if (trig) begin
            // post_rem counts the samples still owed after the trigger one
            w_trig_addr_n  = r_wr_ptr;
            w_start_addr_n = r_wr_ptr - r_p;
            w_post_rem_n   = LAST - r_p;
            w_triggered_n  = 1'b1;
            if (r_p == LAST) begin
              w_state_n = DONE;
              w_done_n  = 1'b1;
            end else begin
              w_state_n = POST;
            end
          end
        end
        POST: begin
          w_post_rem_n = r_post_rem - ONE;
          if (r_post_rem == ONE) begin
            w_state_n = DONE;
            w_done_n  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign wren       = r_wren;
  assign wraddress  = r_wraddress;
  assign data       = r_data;
  assign trig_addr  = r_trig_addr;
  assign start_addr = r_start_addr;
  assign busy       = w_active;
  assign triggered  = r_triggered;
  assign done       = r_done;

endmodule

// File: tb/tb_ips_dbc_capture_wr_ctrl_v1_0.sv
// Directed bench for the capture write controller with a 16-entry buffer.
module tb_ips_dbc_capture_wr_ctrl_v1_0;

  localparam int DD = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          arm;
  logic          abort;
  logic [DD-1:0] pre_trig_num;
  logic          sample_en;
  logic [DW-1:0] din;
  logic          trig;
  logic          wren;
  logic [DD-1:0] wraddress;
  logic [DW-1:0] data;
  logic [DD-1:0] trig_addr;
  logic [DD-1:0] start_addr;
  logic          busy;
  logic          triggered;
  logic          done;

  int errors = 0;
  int checks = 0;

  ips_dbc_capture_wr_ctrl_v1_0 #(.DATA_DEPTH(DD), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort),
    .pre_trig_num(pre_trig_num), .sample_en(sample_en), .din(din), .trig(trig),
    .wren(wren), .wraddress(wraddress), .data(data), .trig_addr(trig_addr),
    .start_addr(start_addr), .busy(busy), .triggered(triggered), .done(done)
  );

  always #5 clk = ~clk;

  // Drives one cycle of inputs and returns 1 time unit after the active edge
  task automatic step(input logic a, input logic ab, input logic se,
                      input logic [DW-1:0] d, input logic t);
    arm = a; abort = ab; sample_en = se; din = d; trig = t;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    checks++; if (wren !== 1'b0) begin errors++; $display("[TB] FAIL reset wren: got %0h want 0", wren); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset busy: got %0h want 0", busy); end
    checks++; if (triggered !== 1'b0) begin errors++; $display("[TB] FAIL reset triggered: got %0h want 0", triggered); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset done: got %0h want 0", done); end
    checks++; if (wraddress !== 4'h0) begin errors++; $display("[TB] FAIL reset wraddress: got %0h want 0", wraddress); end
    checks++; if (data !== 8'h00) begin errors++; $display("[TB] FAIL reset data: got %0h want 0", data); end
    checks++; if (trig_addr !== 4'h0) begin errors++; $display("[TB] FAIL reset trig_addr: got %0h want 0", trig_addr); end
    checks++; if (start_addr !== 4'h0) begin errors++; $display("[TB] FAIL reset start_addr: got %0h want 0", start_addr); end
    #2 rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b1, 8'h55, 1'b1);
    checks++; if (wren !== 1'b0) begin errors++; $display("[TB] FAIL idle wren: got %0h want 0", wren); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL idle busy: got %0h want 0", busy); end
  endtask

  // P=5, trigger on the 8th qualified sample; gap inserts an unqualified cycle before each sample
  task automatic test_basic(input bit gap);
    pre_trig_num = 4'd5;
    step(1'b1, 1'b0, 1'b1, 8'hFF, 1'b1);
    checks++; if (wren !== 1'b0) begin errors++; $display("[TB] FAIL basic arm wren: got %0h want 0", wren); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL basic arm busy: got %0h want 1", busy); end
    for (int k = 0; k < 18; k++) begin
      if (gap) begin
        step(1'b0, 1'b0, 1'b0, 8'h11, 1'b1);
        checks++; if (wren !== 1'b0) begin errors++; $display("[TB] FAIL basic gap wren k=%0d: got %0h want 0", k, wren); end
      end
      step(1'b0, 1'b0, 1'b1, 8'(8'h40 + k), 1'(k == 7));
      checks++; if (wren !== 1'b1) begin errors++; $display("[TB] FAIL basic wren k=%0d: got %0h want 1", k, wren); end
      checks++; if (wraddress !== 4'(k)) begin errors++; $display("[TB] FAIL basic wraddress k=%0d: got %0h want %0h", k, wraddress, 4'(k)); end
      checks++; if (data !== 8'(8'h40 + k)) begin errors++; $display("[TB] FAIL basic data k=%0d: got %0h want %0h", k, data, 8'(8'h40 + k)); end
      checks++; if (triggered !== 1'(k >= 7)) begin errors++; $display("[TB] FAIL basic triggered k=%0d: got %0h want %0h", k, triggered, 1'(k >= 7)); end
      checks++; if (done !== 1'(k == 17)) begin errors++; $display("[TB] FAIL basic done k=%0d: got %0h want %0h", k, done, 1'(k == 17)); end
      checks++; if (busy !== 1'(k != 17)) begin errors++; $display("[TB] FAIL basic busy k=%0d: got %0h want %0h", k, busy, 1'(k != 17)); end
    end
    step(1'b0, 1'b0, 1'b1, 8'h99, 1'b1);
    checks++; if (wren !== 1'b0) begin errors++; $display("[TB] FAIL basic done wren: got %0h want 0", wren); end
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL basic done held: got %0h want 1", done); end
    checks++; if (trig_addr !== 4'd7) begin errors++; $display("[TB] FAIL basic trig_addr: got %0h want 7", trig_addr); end
    checks++; if (start_addr !== 4'd2) begin errors++; $display("[TB] FAIL basic start_addr: got %0h want 2", start_addr); end
  endtask

  task automatic test_early_trig();
    pre_trig_num = 4'd5;
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 17; k++) begin
      step(1'b0, 1'b0, 1'b1, 8'(8'h80 + k), 1'((k <= 3) || (k == 6)));
      checks++; if (wraddress !== 4'(k)) begin errors++; $display("[TB] FAIL early wraddress k=%0d: got %0h want %0h", k, wraddress, 4'(k)); end
      checks++; if (triggered !== 1'(k >= 6)) begin errors++; $display("[TB] FAIL early triggered k=%0d: got %0h want %0h", k, triggered, 1'(k >= 6)); end
      checks++; if (done !== 1'(k == 16)) begin errors++; $display("[TB] FAIL early done k=%0d: got %0h want %0h", k, done, 1'(k == 16)); end
    end
    checks++; if (trig_addr !== 4'd6) begin errors++; $display("[TB] FAIL early trig_addr: got %0h want 6", trig_addr); end
    checks++; if (start_addr !== 4'd1) begin errors++; $display("[TB] FAIL early start_addr: got %0h want 1", start_addr); end
  endtask

  task automatic test_p_zero();
    pre_trig_num = 4'd0;
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL p0 busy: got %0h want 1", busy); end
    for (int k = 0; k < 16; k++) begin
      step(1'b0, 1'b0, 1'b1, 8'(8'hC0 + k), 1'(k == 0));
      checks++; if (wren !== 1'b1) begin errors++; $display("[TB] FAIL p0 wren k=%0d: got %0h want 1", k, wren); end
      checks++; if (wraddress !== 4'(k)) begin errors++; $display("[TB] FAIL p0 wraddress k=%0d: got %0h want %0h", k, wraddress, 4'(k)); end
      checks++; if (done !== 1'(k == 15)) begin errors++; $display("[TB] FAIL p0 done k=%0d: got %0h want %0h", k, done, 1'(k == 15)); end
    end
    step(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
    checks++; if (wren !== 1'b0) begin errors++; $display("[TB] FAIL p0 after wren: got %0h want 0", wren); end
    checks++; if (trig_addr !== 4'd0) begin errors++; $display("[TB] FAIL p0 trig_addr: got %0h want 0", trig_addr); end
    checks++; if (start_addr !== 4'd0) begin errors++; $display("[TB] FAIL p0 start_addr: got %0h want 0", start_addr); end
  endtask

  task automatic test_p_max();
    pre_trig_num = 4'd15;
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 21; k++) begin
      step(1'b0, 1'b0, 1'b1, 8'(k), 1'((k < 3) || (k == 20)));
      checks++; if (wraddress !== 4'(k)) begin errors++; $display("[TB] FAIL pmax wraddress k=%0d: got %0h want %0h", k, wraddress, 4'(k)); end
      checks++; if (triggered !== 1'(k == 20)) begin errors++; $display("[TB] FAIL pmax triggered k=%0d: got %0h want %0h", k, triggered, 1'(k == 20)); end
      checks++; if (done !== 1'(k == 20)) begin errors++; $display("[TB] FAIL pmax done k=%0d: got %0h want %0h", k, done, 1'(k == 20)); end
    end
    step(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
    checks++; if (wren !== 1'b0) begin errors++; $display("[TB] FAIL pmax after wren: got %0h want 0", wren); end
    checks++; if (trig_addr !== 4'd4) begin errors++; $display("[TB] FAIL pmax trig_addr: got %0h want 4", trig_addr); end
    checks++; if (start_addr !== 4'd5) begin errors++; $display("[TB] FAIL pmax start_addr: got %0h want 5", start_addr); end
  endtask

  task automatic test_abort();
    pre_trig_num = 4'd5;
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 11; k++) begin
      step(1'b0, 1'b0, 1'b1, 8'(8'h20 + k), 1'(k == 7));
    end
    checks++; if (triggered !== 1'b1) begin errors++; $display("[TB] FAIL abort pre triggered: got %0h want 1", triggered); end
    checks++; if (wraddress !== 4'd10) begin errors++; $display("[TB] FAIL abort pre wraddress: got %0h want a", wraddress); end
    step(1'b0, 1'b1, 1'b1, 8'h77, 1'b0);
    checks++; if (wren !== 1'b1) begin errors++; $display("[TB] FAIL abort staged wren: got %0h want 1", wren); end
    checks++; if (wraddress !== 4'd11) begin errors++; $display("[TB] FAIL abort staged wraddress: got %0h want b", wraddress); end
    checks++; if (data !== 8'h77) begin errors++; $display("[TB] FAIL abort staged data: got %0h want 77", data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort busy: got %0h want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL abort done: got %0h want 0", done); end
    checks++; if (triggered !== 1'b0) begin errors++; $display("[TB] FAIL abort triggered: got %0h want 0", triggered); end
    checks++; if (trig_addr !== 4'd7) begin errors++; $display("[TB] FAIL abort trig_addr held: got %0h want 7", trig_addr); end
    checks++; if (start_addr !== 4'd2) begin errors++; $display("[TB] FAIL abort start_addr held: got %0h want 2", start_addr); end
    step(1'b0, 1'b0, 1'b1, 8'h78, 1'b0);
    checks++; if (wren !== 1'b0) begin errors++; $display("[TB] FAIL abort after wren: got %0h want 0", wren); end
    step(1'b1, 1'b0, 1'b1, 8'h79, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'h7A, 1'b0);
    checks++; if (wren !== 1'b1) begin errors++; $display("[TB] FAIL rearm wren: got %0h want 1", wren); end
    checks++; if (wraddress !== 4'd0) begin errors++; $display("[TB] FAIL rearm wraddress: got %0h want 0", wraddress); end
  endtask

  task automatic test_reset_mid();
    pre_trig_num = 4'd3;
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b0, 1'b1, 8'(8'h60 + k), 1'b0);
    end
    checks++; if (wraddress !== 4'd4) begin errors++; $display("[TB] FAIL rstmid pre wraddress: got %0h want 4", wraddress); end
    rst_n = 1'b0;
    #1;
    checks++; if (wren !== 1'b0) begin errors++; $display("[TB] FAIL rstmid wren: got %0h want 0", wren); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid busy: got %0h want 0", busy); end
    checks++; if (wraddress !== 4'd0) begin errors++; $display("[TB] FAIL rstmid wraddress: got %0h want 0", wraddress); end
    checks++; if (data !== 8'h00) begin errors++; $display("[TB] FAIL rstmid data: got %0h want 0", data); end
    checks++; if (trig_addr !== 4'd0) begin errors++; $display("[TB] FAIL rstmid trig_addr: got %0h want 0", trig_addr); end
    checks++; if (start_addr !== 4'd0) begin errors++; $display("[TB] FAIL rstmid start_addr: got %0h want 0", start_addr); end
    #2 rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid idle busy: got %0h want 0", busy); end
  endtask

  task automatic test_arm_in_done();
    pre_trig_num = 4'd0;
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 16; k++) begin
      step(1'b0, 1'b0, 1'b1, 8'(k), 1'(k == 0));
    end
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL armdone done: got %0h want 1", done); end
    step(1'b1, 1'b0, 1'b1, 8'hEE, 1'b1);
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL armdone cleared: got %0h want 0", done); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL armdone busy: got %0h want 1", busy); end
    checks++; if (wren !== 1'b0) begin errors++; $display("[TB] FAIL armdone arm wren: got %0h want 0", wren); end
    step(1'b0, 1'b0, 1'b1, 8'h5A, 1'b0);
    checks++; if (wren !== 1'b1) begin errors++; $display("[TB] FAIL armdone wren: got %0h want 1", wren); end
    checks++; if (wraddress !== 4'd0) begin errors++; $display("[TB] FAIL armdone wraddress: got %0h want 0", wraddress); end
    checks++; if (data !== 8'h5A) begin errors++; $display("[TB] FAIL armdone data: got %0h want 5a", data); end
  endtask

  initial begin
    rst_n = 1'b0; arm = 1'b0; abort = 1'b0; sample_en = 1'b0;
    din = '0; trig = 1'b0; pre_trig_num = '0;
    test_reset();
    test_basic(1'b0);
    test_basic(1'b1);
    test_early_trig();
    test_p_zero();
    test_p_max();
    test_abort();
    test_reset_mid();
    test_arm_in_done();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
